// File: rtl/nib_deser.sv
// Serial-to-nibble deserializer with a small output FIFO feeding the qd classifier.
// Define NIB_DESER_PARITY_EN for 5-bit frames (4 data + even parity) and a perr pulse.
module nib_deser #(
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       sin_vld,
  input  logic       sof,
  output logic [3:0] nib,
  output logic       nib_vld,
  input  logic       out_rdy,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       frm_err
`ifdef NIB_DESER_PARITY_EN
  ,
  output logic       perr
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  // Bit count at which the incoming strobe is the final bit of a frame.
`ifdef NIB_DESER_PARITY_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif

  typedef enum logic {HUNT, SHIFT} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] sreg_q, sreg_d;
  logic       push;
  logic [3:0] push_data;
  logic       frm_err_d;
`ifdef NIB_DESER_PARITY_EN
  logic       perr_d;
`endif

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fcnt_q;
  logic          full, pop, wr_en, ovf_set;

  function automatic logic [3:0] shift_in(input logic [3:0] cur, input logic b);
    if (MSB_FIRST != 0) return {cur[2:0], b};
    else                return {b, cur[3:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      sreg_q  <= '0;
      frm_err <= 1'b0;
`ifdef NIB_DESER_PARITY_EN
      perr    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      frm_err <= frm_err_d;
`ifdef NIB_DESER_PARITY_EN
      perr    <= perr_d;
`endif
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    push      = 1'b0;
    push_data = sreg_q;
    frm_err_d = 1'b0;
`ifdef NIB_DESER_PARITY_EN
    perr_d    = 1'b0;
`endif
    if (sin_vld) begin
      if (sof) begin
        // A sof always opens a new frame; only a half-built frame is an error.
        frm_err_d = (state_q == SHIFT);
        state_d   = SHIFT;
        cnt_d     = 3'd1;
        sreg_d    = shift_in(4'h0, sin);
      end else if (state_q == SHIFT) begin
        if (cnt_q == LAST) begin
          state_d = HUNT;
          cnt_d   = '0;
`ifdef NIB_DESER_PARITY_EN
          push      = ((^sreg_q) == sin);
          perr_d    = ((^sreg_q) != sin);
          push_data = sreg_q;
`else
          sreg_d    = shift_in(sreg_q, sin);
          push      = 1'b1;
          push_data = shift_in(sreg_q, sin);
`endif
        end else begin
          cnt_d  = cnt_q + 3'd1;
          sreg_d = shift_in(sreg_q, sin);
        end
      end
    end
  end

  assign nib_vld = (fcnt_q != '0);
  assign nib     = mem[rd_ptr_q];
  assign full    = (fcnt_q == DEPTH_CNT);
  assign pop     = nib_vld & out_rdy;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  // NOTE: the storage is reset too, so nib reads 4'h0 and no stale data survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr_q] <= push_data;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop)      fcnt_q <= fcnt_q + 1'b1;
      else if (!wr_en && pop) fcnt_q <= fcnt_q - 1'b1;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nib_deser.sv
// Directed self-checking bench for nib_deser; an LSB-first copy runs alongside
// on the same inputs to cover the bit-order parameter.
module tb_nib_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b0, sin_vld = 1'b0, sof = 1'b0;
  logic       out_rdy = 1'b0, ovf_clr = 1'b0;
  logic [3:0] nib, nib_l;
  logic       nib_vld, nib_vld_l, ovf, ovf_l, frm_err, frm_err_l;
`ifdef NIB_DESER_PARITY_EN
  logic       perr, perr_l;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nib_deser #(.MSB_FIRST(1), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_vld(sin_vld), .sof(sof),
    .nib(nib), .nib_vld(nib_vld), .out_rdy(out_rdy), .ovf(ovf),
    .ovf_clr(ovf_clr), .frm_err(frm_err)
`ifdef NIB_DESER_PARITY_EN
    , .perr(perr)
`endif
  );

  nib_deser #(.MSB_FIRST(0), .FIFO_DEPTH(2)) dut_l (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_vld(sin_vld), .sof(sof),
    .nib(nib_l), .nib_vld(nib_vld_l), .out_rdy(out_rdy), .ovf(ovf_l),
    .ovf_clr(ovf_clr), .frm_err(frm_err_l)
`ifdef NIB_DESER_PARITY_EN
    , .perr(perr_l)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic send_bit(input logic s, input logic b);
    sof = s; sin = b; sin_vld = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    sof = 1'b0; sin = 1'b0; sin_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_par(input logic [3:0] bits);
`ifdef NIB_DESER_PARITY_EN
    send_bit(1'b0, ^bits);
`else
    if (bits === 4'bxxxx) $display("unused parity data");
`endif
  endtask

  // bits[3] is sent first, with sof.
  task automatic send_nib(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) begin
      send_bit(i == 3, bits[i]);
      if (i == 3) check("frm_err_clean_sof", frm_err, 1'b0);
    end
    send_par(bits);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_nib", nib, 4'h0);
    check("rst_nib_vld", nib_vld, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_frm_err", frm_err, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame 1,0,1,1 with out_rdy high: one-cycle hold
    out_rdy = 1'b1;
    send_nib(4'b1011);
    check("t1_vld", nib_vld, 1'b1);
    check("t1_nib_msb", nib, 4'hB);
    check("t1_vld_lsb", nib_vld_l, 1'b1);
    check("t1_nib_lsb", nib_l, 4'hD);
    idle(1);
    check("t1_vld_gone", nib_vld, 1'b0);

    // Overflow: three frames into a 2-deep FIFO
    out_rdy = 1'b0;
    send_nib(4'h2);
    send_nib(4'h5);
    check("t2_vld", nib_vld, 1'b1);
    check("t2_head", nib, 4'h2);
    check("t2_no_ovf_yet", ovf, 1'b0);
    send_nib(4'h9);
    check("t2_ovf", ovf, 1'b1);
    check("t2_ovf_lsb", ovf_l, 1'b1);
    idle(1);
    check("t2_head_stable", nib, 4'h2);
    out_rdy = 1'b1;
    idle(1);
    check("t2_pop1_vld", nib_vld, 1'b1);
    check("t2_pop1_nib", nib, 4'h5);
    idle(1);
    check("t2_no_9", nib_vld, 1'b0);
    out_rdy = 1'b0;
    check("t2_ovf_sticky", ovf, 1'b1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("t2_ovf_clr", ovf, 1'b0);

    // Full FIFO, completion coincides with a pop
    send_nib(4'h3);
    send_nib(4'h7);
    check("t3_head", nib, 4'h3);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
`ifdef NIB_DESER_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    out_rdy = 1'b1;
    send_bit(1'b0, 1'b0);
    check("t3_no_ovf", ovf, 1'b0);
    check("t3_head7", nib, 4'h7);
    idle(1);
    check("t3_vld_a", nib_vld, 1'b1);
    check("t3_nib_a", nib, 4'hA);
    idle(1);
    check("t3_empty", nib_vld, 1'b0);
    check("t3_no_ovf_end", ovf, 1'b0);

    // Framing error: sof+1,1 then sof+0,0,1,0
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    check("t4_frm_err", frm_err, 1'b1);
    check("t4_frm_err_lsb", frm_err_l, 1'b1);
    check("t4_no_vld", nib_vld, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t4_frm_err_once", frm_err, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_par(4'h2);
    check("t4_vld", nib_vld, 1'b1);
    check("t4_nib", nib, 4'h2);
    check("t4_nib_lsb", nib_l, 4'h4);
    idle(1);
    check("t4_empty", nib_vld, 1'b0);
    check("t4_frm_err_end", frm_err, 1'b0);

    // Bits without sof in HUNT are ignored
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    check("t5_hunt_no_vld", nib_vld, 1'b0);
    check("t5_hunt_no_err", frm_err, 1'b0);

    // Asynchronous reset mid-frame with the FIFO holding data
    out_rdy = 1'b0;
    send_nib(4'hC);
    check("t5_pre_vld", nib_vld, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    sin_vld = 1'b0; sof = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_vld", nib_vld, 1'b0);
    check("t5_async_nib", nib, 4'h0);
    check("t5_async_ovf", ovf, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    check("t5_no_partial", nib_vld, 1'b0);
    idle(1);
    send_nib(4'h6);
    check("t5_vld6", nib_vld, 1'b1);
    check("t5_nib6", nib, 4'h6);
    idle(1);

`ifdef NIB_DESER_PARITY_EN
    // Parity: 0,1,0,1 + 0 is good, + 1 is rejected
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    check("p_vld", nib_vld, 1'b1);
    check("p_nib", nib, 4'h5);
    check("p_no_perr", perr, 1'b0);
    idle(1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    check("p_perr", perr, 1'b1);
    check("p_no_push", nib_vld, 1'b0);
    idle(1);
    check("p_perr_pulse", perr, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nib_deser.md
# nib_deser

Serial-to-nibble deserializer that sits directly upstream of the `qd` nibble classifier. It assembles 4-bit nibbles from a framed serial bit stream and buffers them in a small output FIFO. It presents them on a valid/ready interface whose `nib` output drives the classifier's 4-bit `A` input. Overflow and framing faults are flagged so that downstream P/D statistics can be qualified.

## Interface
- `MSB_FIRST`, 1: 1 = first bit of a frame lands in `nib[3]`; 0 = first bit lands in `nib[0]`.
- `FIFO_DEPTH`, 2: output FIFO entries; legal values 2 or 4.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `sin`  in  1  serial data bit, sampled only when `sin_vld`=1.
- `sin_vld`  in  1  bit strobe.
- `sof`  in  1  start of frame; meaningful only with `sin_vld`=1.
- `nib`  out  4  FIFO head nibble, feeds `qd.A`.
- `nib_vld`  out  1  FIFO non-empty.
- `out_rdy`  in  1  consumer accepts `nib` when `nib_vld & out_rdy`.
- `ovf`  out  1  sticky: a completed nibble was dropped because the FIFO was full.
- `ovf_clr`  in  1  synchronous clear of `ovf`.
- `frm_err`  out  1  one-cycle pulse: partial frame aborted by `sof`.

## Operation
- FSM has two states:
  - HUNT: the reset state. Bits without `sof` are ignored.
  - SHIFT: collecting the bits of a frame.
- HUNT -> SHIFT: on `sin_vld & sof`. That bit is bit 0 of the frame, and the bit count becomes 1.
- In SHIFT, each `sin_vld` shifts `sin` in and increments the count.
- When the count reaches 4, the nibble is complete:
  - it is pushed to the FIFO;
  - the FSM returns to HUNT.
- The next frame always needs a new `sof`. A `sof` on the very next strobe is legal and is not an error.
- `sof` while in SHIFT with a count of 1..3:
  - the partial frame is discarded;
  - `frm_err` pulses;
  - the current bit starts a new frame (the count becomes 1).
- Bit order:
  - `MSB_FIRST`=1: the shift register shifts left, so frame bits 1,0,1,1 give `nib`=4'hB.
  - `MSB_FIRST`=0: the same frame bits give 4'hD.
- FIFO:
  - push on nibble completion; pop on `nib_vld & out_rdy`;
  - `nib` is valid and stable while `nib_vld`=1 and no pop has occurred;
  - order is first-in first-out.
- Full FIFO with a completing nibble:
  - if there is no pop that cycle, the nibble is dropped and `ovf` is set;
  - if there is a pop the same cycle, the push is accepted and `ovf` is unchanged.
- `ovf` clearing: `ovf_clr` clears `ovf`. If a new overflow occurs in the same cycle as `ovf_clr`, the set wins.
- Reset values: FSM=HUNT, count=0, shift register=0, FIFO empty, `nib`=4'h0, `nib_vld`=0, `ovf`=0, `frm_err`=0.

## Timing
- Latency: the last bit is strobed at edge N, and `nib_vld`=1 with the new nibble at the FIFO head after edge N (usable in cycle N+1), provided the FIFO was empty.
- Throughput: one nibble per 4 strobes. Strobes may arrive on back-to-back cycles with no idle cycle between frames.
- `frm_err` is registered: it is high for exactly the cycle after the aborting edge.
- Asserting `rst_n` low mid-frame or with the FIFO non-empty:
  - all outputs take their reset values immediately, without waiting for a clock edge;
  - no partial or buffered data survives.
- Removal of reset is synchronised by the surrounding design. The block accepts a `sof` on the first edge after `rst_n` rises.
- `out_rdy` may be tied high. Then each nibble is held on `nib` for exactly one cycle.

## Configuration
- `NIB_DESER_PARITY_EN` defined:
  - frames are 5 bits: 4 data bits, then 1 even-parity bit over the data;
  - the parity bit is never shifted into `nib`;
  - a frame with a parity mismatch is not pushed, and `perr` (out, 1, one-cycle registered pulse) fires;
  - `perr` resets to 0;
  - a `sof` abort can occur at counts 1..4.
- Not defined:
  - frames are 4 bits;
  - the `perr` port does not exist;
  - behaviour is exactly as described above.

## Test plan
- Reset, then `sof`+bits 1,0,1,1 on consecutive strobes with `out_rdy`=1 -> `nib`=4'hB and `nib_vld`=1 for one cycle after the 4th edge. With `MSB_FIRST`=0 -> 4'hD.
- `out_rdy`=0, send 3 frames (4'h2, 4'h5, 4'h9) with `FIFO_DEPTH`=2 -> FIFO holds 2 then 5, and `ovf`=1 after the third frame. Raise `out_rdy` -> 2 then 5 are popped, and 9 never appears. Pulse `ovf_clr` -> `ovf`=0.
- FIFO full, with the last bit of frame 4'hA completing in the same cycle as a pop -> no `ovf`, and the pops that follow return the remaining entry then A.
- `sof`+1,1, then `sof`+0,0,1,0 -> `frm_err` pulses once, and the only nibble output is 4'h2.
- Bits with no `sof` while in HUNT -> no `nib_vld`, no `frm_err`. Drive `rst_n` low after 2 bits of a frame, then release -> outputs reset asynchronously, and the next clean frame 4'h6 is output correctly.
- With `NIB_DESER_PARITY_EN`: frame 0,1,0,1 + parity 0 -> `nib`=4'h5. The same data with parity 1 -> `perr` pulse and no push.
